four_bit_countdown_timer: RTL
=============================

// Module: four_bit_countdown_timer
// PURPOSE
//  Loadable 4-bit down-counter/timer; counterpart to the free-running 4-bit up-counter.
//  - Host loads a start value, issues start; block decrements once every PRESCALE clocks.
//  - Emits a one-cycle done pulse when the count reaches zero.
//  - Used as a timeout/interval generator next to the up-counter in the same clock domain.
// PARAMETERS
//  WIDTH     4  counter/load width in bits
//  PRESCALE  1  clocks per decrement (>=1); PRESCALE=1 means decrement every clock
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      reset, synchronous, active-high
//  load      in   1      latch load_val into count and reload register; aborts any run
//  load_val  in   WIDTH  value captured on load
//  start     in   1      begin counting (IDLE) or resume (HOLD)
//  pause     in   1      freeze count and prescaler while in RUN
//  count     out  WIDTH  current count (registered)
//  busy      out  1      high in RUN or HOLD
//  done      out  1      one-cycle pulse, registered, on terminal count
//  zero      out  1      combinational (count == 0)
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, reload reg=0, prescaler=0, busy=0, done=0; zero=1.
//  - Input priority per edge: reset > load > start > pause.
//  - States IDLE, RUN, HOLD, DONE. busy=1 in RUN/HOLD; done=1 only in DONE.
//  - load (any state): count<=load_val, reload<=load_val, prescaler<=0, state->IDLE.
//  - IDLE + start, count!=0: ->RUN, prescaler<=0. IDLE + start, count==0: ->DONE (done next cycle).
//  - RUN: prescaler increments; at PRESCALE-1 it wraps to 0 and count decrements (tick).
//  - RUN + tick with count==1: count<=0, state->DONE. Latency: start edge to done high = N*PRESCALE clocks.
//  - RUN + pause (no load/start): ->HOLD; count and prescaler frozen. pause outside RUN ignored.
//  - RUN + start + pause same edge: start wins, stay in RUN.
//  - HOLD + start: ->RUN, prescaler resumes from held value. start in RUN/DONE ignored.
//  - DONE: lasts exactly one cycle, then ->IDLE with count=0 (macro off).
//  - No wrap-around: count never decrements below 0.
//  - Reset or load mid-run: takes effect at that edge; no done pulse is generated.
// CONFIGURATION
//  - FOUR_BIT_TIMER_AUTO_RELOAD_EN defined:
//    - Terminal tick sets count<=reload and done=1 for one cycle; state stays RUN (busy stays 1).
//    - Periodic done every reload*PRESCALE clocks; pause/load/reset still apply.
//    - reload==0 with start behaves as macro off (single DONE, ->IDLE).
//  - Macro undefined: one-shot behaviour as above; reload register may be omitted.
// TESTING
//  - Reset: assert reset 2 clk -> count=0, busy=0, done=0, zero=1.
//  - One-shot: load 5, start, PRESCALE=1 -> count 5,4,3,2,1,0; done high exactly 5 clk after start, busy low after.
//  - Prescale: PRESCALE=3, load 2, start -> count steps every 3 clk; done 6 clk after start.
//  - Pause: load 8, start, pause at count=5 for 4 clk, start -> count holds 5, resumes; done delayed by 4+1 clk.
//  - Edge cases: start with count=0 -> done next cycle; load 3 during RUN at count=6 -> count=3, IDLE, no done.
//  - AUTO_RELOAD_EN: load 3, start -> done pulses every 3 clk, count 3,2,1,3,2,1..., busy stays 1.

Source files
------------

// File: rtl/four_bit_countdown_timer.sv
// ---------------------------------------------------------------------------
// four_bit_countdown_timer
//
// Loadable down-counter / timer. The host loads a start value and issues
// start. The count then decrements once every PRESCALE clocks. When it
// reaches zero, the block emits a one-cycle registered done pulse.
//
// Optional feature: define FOUR_BIT_TIMER_AUTO_RELOAD_EN to enable periodic
// mode. In this mode the terminal tick reloads the count and stays in RUN.
// A reload value of zero still ends in a single DONE.
//
// Parameters
//    WIDTH     counter / load width in bits
//    PRESCALE  clocks per decrement (>= 1)
//
// Ports
//    clk       in   rising-edge clock
//    reset     in   synchronous, active-high reset
//    load      in   capture load_val into count (and reload); aborts any run
//    load_val  in   value captured on load
//    start     in   begin counting from IDLE, or resume from HOLD
//    pause     in   freeze count and prescaler while in RUN
//    count     out  current count (registered)
//    busy      out  high in RUN or HOLD
//    done      out  one-cycle registered pulse on terminal count
//    zero      out  combinational (count == 0)
// ---------------------------------------------------------------------------
module four_bit_countdown_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   // A prescaler of PRESCALE=1 still needs a one-bit register. That bit
   // simply stays at zero, so every RUN cycle is a tick.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_count, w_count_next;
   logic [PW-1:0]    r_presc, w_presc_next;
   logic             r_done,  w_done_next;
   logic             w_tick;

`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] r_reload, w_reload_next;
`endif

   assign w_tick = (r_presc == P_LAST);

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_presc_next = r_presc;
      w_done_next  = 1'b0;
`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
      w_reload_next = r_reload;
`endif

      if (load) begin
         w_count_next = load_val;
         w_presc_next = '0;
         w_state_next = S_IDLE;
`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
         w_reload_next = load_val;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_presc_next = '0;
                  if (r_count != '0) begin
                     w_state_next = S_RUN;
                  end else begin
                     // Nothing to count: report completion on the next cycle.
                     w_state_next = S_DONE;
                     w_done_next  = 1'b1;
                  end
               end
            end

            S_RUN: begin
               // If start and pause arrive together, start wins and the run continues.
               if (pause && !start) begin
                  w_state_next = S_HOLD;
               end else if (w_tick) begin
                  w_presc_next = '0;
                  // The <= guard also catches zero, so the count can never wrap.
                  if (r_count <= CNT_ONE) begin
                     w_done_next = 1'b1;
`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
                     if (r_reload != '0) begin
                        w_count_next = r_reload;
                     end else begin
                        w_count_next = '0;
                        w_state_next = S_DONE;
                     end
`else
                     w_count_next = '0;
                     w_state_next = S_DONE;
`endif
                  end else begin
                     w_count_next = r_count - CNT_ONE;
                  end
               end else begin
                  w_presc_next = r_presc + PW'(1);
               end
            end

            S_HOLD: begin
               // Resume keeps the prescaler phase it had when paused.
               if (start) begin
                  w_state_next = S_RUN;
               end
            end

            S_DONE: begin
               w_state_next = S_IDLE;
               w_count_next = '0;
            end

            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_presc <= '0;
         r_done  <= 1'b0;
`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
         r_reload <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_presc <= w_presc_next;
         r_done  <= w_done_next;
`ifdef FOUR_BIT_TIMER_AUTO_RELOAD_EN
         r_reload <= w_reload_next;
`endif
      end
   end

   assign count = r_count;
   assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
   assign done  = r_done;
   assign zero  = (r_count == '0);

endmodule
